// File: rtl/serial_and20.sv
// Bit-serial AND: collects WIDTH LSB-first bit pairs into a parallel word and holds it until taken.
// Optional macro SERIAL_AND20_PARITY_EN adds out_par, the XOR of all out_s bits.
module serial_and20 #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [4:0]       bit_cnt,
`ifdef SERIAL_AND20_PARITY_EN
  output logic             out_par,
`endif
  output logic             state_dbg
);

  // Handshakes: a transfer happens only on a cycle where valid and ready are both 1.
  // in_ready is high exactly in COLLECT and out_valid exactly in HOLD, so the two sides never overlap.
  localparam int CW = 6;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          take;
  logic          last;

  assign last      = (cnt == CW'(WIDTH - 1));
  assign bit_cnt   = cnt[4:0];
  assign state_dbg = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) state <= COLLECT;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    take      = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        take     = in_valid;
        if (take && last) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // out_s is only overwritten bit by bit; a handshake just rewinds the counter.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt   <= '0;
      out_s <= '0;
    end else if (take) begin
      cnt <= cnt + CW'(1);
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt == CW'(i)) out_s[i] <= in_a & in_b;
      end
    end else if (out_valid && out_ready) begin
      cnt <= '0;
    end
  end

`ifdef SERIAL_AND20_PARITY_EN
  assign out_par = ^out_s;
`endif

endmodule

// File: tb/tb_serial_and20.sv
// Directed self-checking bench for serial_and20 (WIDTH=20).
module tb_serial_and20;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_a, in_b, out_ready;
  logic        in_ready, out_valid, state_dbg;
  logic [19:0] out_s;
  logic [4:0]  bit_cnt;
`ifdef SERIAL_AND20_PARITY_EN
  logic        out_par;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_and20 #(.WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .bit_cnt(bit_cnt),
`ifdef SERIAL_AND20_PARITY_EN
    .out_par(out_par),
`endif
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word; idle gaps of glen cycles follow bits g1 and g2.
  // stalls counts cycles spent waiting for in_ready before a bit could be accepted.
  task automatic send_word(input logic [19:0] a, input logic [19:0] b,
                           input int g1, input int g2, input int glen, output int stalls);
    int guard;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_a = a[k];
      in_b = b[k];
      guard = 0;
      while (!in_ready && guard < 50) begin
        tick();
        stalls++;
        guard++;
      end
      if (guard == 50) check("ready_timeout", 32'(in_ready), 32'd1);
      tick();
      check($sformatf("bitcnt_%0d", k), 32'(bit_cnt), 32'(k + 1));
      if (k == g1 || k == g2) begin
        in_valid = 1'b0;
        for (int g = 0; g < glen; g++) begin
          in_a = 1'($urandom_range(0, 1));
          in_b = 1'($urandom_range(0, 1));
          tick();
          check("bitcnt_stall", 32'(bit_cnt), 32'(k + 1));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_hold(input string tag, input logic [19:0] exp);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_s"}, 32'(out_s), 32'(exp));
`ifdef SERIAL_AND20_PARITY_EN
    check({tag, "_par"}, 32'(out_par), 32'(^exp));
`endif
  endtask

  initial begin
    int st, t0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_cnt", 32'(bit_cnt), 32'd0);
    check("rst_s", 32'(out_s), 32'd0);

    // gapless word, result one cycle after last pair, valid for one cycle only
    out_ready = 1'b1;
    t0 = cyc;
    send_word(20'hFFFFF, 20'hA5A5A, -1, -1, 0, st);
    check("w1_lat", 32'(cyc - t0), 32'd20);
    check("w1_cnt", 32'(bit_cnt), 32'd20);
    check_hold("w1", 20'hA5A5A);
    tick();
    check("w1_onecyc", 32'(out_valid), 32'd0);
    check("w1_cnt0", 32'(bit_cnt), 32'd0);

    // gaps of 3 idle cycles after bits 4 and 11
    t0 = cyc;
    send_word(20'h12345, 20'h0F0F0, 4, 11, 3, st);
    check("w2_lat", 32'(cyc - t0), 32'd26);
    check_hold("w2", 20'h02040);
    tick();

    // back-pressure: input ignored while holding
    out_ready = 1'b0;
    send_word(20'h00001, 20'h00001, -1, -1, 0, st);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = 1'($urandom_range(0, 1));
      in_b = 1'($urandom_range(0, 1));
      check_hold("bp", 20'h00001);
      check("bp_cnt", 32'(bit_cnt), 32'd20);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_cnt0", 32'(bit_cnt), 32'd0);
    check("bp_keep", 32'(out_s), 32'h00001);
    check("bp_ready", 32'(in_ready), 32'd1);

    // abort after 10 pairs, then a fresh word
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1;
      tick();
    end
    check("clr_pre", 32'(bit_cnt), 32'd10);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_cnt", 32'(bit_cnt), 32'd0);
    check("clr_s", 32'(out_s), 32'd0);
    send_word(20'h00003, 20'h00001, -1, -1, 0, st);
    check_hold("clr_w", 20'h00001);
    tick();

    // reset while in HOLD
    out_ready = 1'b0;
    send_word(20'hFFFFF, 20'hFFFFF, -1, -1, 0, st);
    check_hold("rh", 20'hFFFFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rh_valid", 32'(out_valid), 32'd0);
    check("rh_s", 32'(out_s), 32'd0);
    check("rh_cnt", 32'(bit_cnt), 32'd0);
    check("rh_ready", 32'(in_ready), 32'd1);

    // back-to-back words, exactly one not-ready cycle in between
    out_ready = 1'b1;
    send_word(20'hAAAAA, 20'hFFFFF, -1, -1, 0, st);
    check_hold("bb1", 20'hAAAAA);
    send_word(20'h55555, 20'hFFFFF, -1, -1, 0, st);
    check("bb_stalls", 32'(st), 32'd1);
    check_hold("bb2", 20'h55555);
    tick();
    check("bb_done", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
